// File: rtl/toggle_event_receiver.sv
// toggle_event_receiver
//   Receive end of a 2-phase toggle link. Each level flip on toggle_in marks
//   one event, and data_in is held stable alongside it. The block synchronizes
//   the toggle and decodes each flip into a single-cycle event. It captures
//   the bundled word into a one-entry valid/ready output register, and it
//   flips ack_toggle once for every accepted event.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   toggle_in    event toggle from the sender (asynchronous to clk)
//   data_in      bundled data, stable from a toggle flip until the matching ack flip
//   ack_toggle   flips once per accepted event
//   out_valid    out_data holds an unconsumed word
//   out_ready    downstream accepts the word when out_valid & out_ready
//   out_data     captured word
//   overflow     sticky: an event arrived with no room and was dropped
//   clr_ovf      synchronous clear of overflow (a same-cycle drop wins)
//   event_count  accepted-event count, wraps modulo 2^CNT_W
//
// SYNC_STAGES must be at least 2.

module toggle_event_receiver #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              toggle_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              ack_toggle,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              overflow,
  input  logic              clr_ovf,
  output logic [CNT_W-1:0]  event_count
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   tog_s;
  logic                   tog_prev;
  logic                   evt;

  state_t                 state_q;
  state_t                 state_d;
  logic [DATA_W-1:0]      data_q;
  logic [DATA_W-1:0]      data_d;
  logic                   ack_q;
  logic                   ack_d;
  logic                   ovf_q;
  logic                   ovf_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;

  // Toggle synchronizer. Only toggle_in crosses here; data_in is held stable
  // by the sender until the ack returns, so it is sampled directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      tog_prev <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], toggle_in};
      tog_prev <= tog_s;
    end
  end

  assign tog_s = sync_q[SYNC_STAGES-1];

  // Each level change of the synchronized toggle yields exactly one evt cycle.
  assign evt = tog_s ^ tog_prev;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      ack_q   <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    ack_d   = ack_q;
    cnt_d   = cnt_q;
    // The clear is applied first so that a drop in the same cycle overrides it.
    ovf_d   = clr_ovf ? 1'b0 : ovf_q;

    unique case (state_q)
      EMPTY: begin
        if (evt) begin
          data_d  = data_in;
          ack_d   = ~ack_q;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = FULL;
        end
      end

      FULL: begin
        if (evt) begin
          if (out_ready) begin
            // The held word is consumed and the new word is captured in the same cycle.
            data_d  = data_in;
            ack_d   = ~ack_q;
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = FULL;
          end else begin
            // No room: drop the event without an ack so that the sender stalls.
            ovf_d   = 1'b1;
          end
        end else if (out_ready) begin
          state_d = EMPTY;
        end
      end

      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  assign out_valid   = (state_q == FULL);
  assign out_data    = data_q;
  assign ack_toggle  = ack_q;
  assign overflow    = ovf_q;
  assign event_count = cnt_q;

endmodule
